// File: rtl/antisat_sweep_pkg.sv
// Shared definitions for the Anti-SAT key sweeper: FSM states, default widths
// and maximal-length Galois LFSR tap masks for widths 8..64.
package antisat_sweep_pkg;

    localparam int DEF_KEY_W = 8;
    localparam int DEF_IN_W  = 36;
    localparam int DEF_OUT_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        CHECK,
        NEXT_KEY,
        DONE
    } sweep_state_t;

    function automatic logic [63:0] tap_bit(input int unsigned t);
        return 64'd1 << (t - 1);
    endfunction

    // Tap positions follow the classic maximal-length table; bit (t-1) set for tap t.
    function automatic logic [63:0] lfsr_taps(input int unsigned width);
        case (width)
            8:  return tap_bit(8)  | tap_bit(6)  | tap_bit(5)  | tap_bit(4);
            9:  return tap_bit(9)  | tap_bit(5);
            10: return tap_bit(10) | tap_bit(7);
            11: return tap_bit(11) | tap_bit(9);
            12: return tap_bit(12) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
            13: return tap_bit(13) | tap_bit(4)  | tap_bit(3)  | tap_bit(1);
            14: return tap_bit(14) | tap_bit(5)  | tap_bit(3)  | tap_bit(1);
            15: return tap_bit(15) | tap_bit(14);
            16: return tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
            17: return tap_bit(17) | tap_bit(14);
            18: return tap_bit(18) | tap_bit(11);
            19: return tap_bit(19) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
            20: return tap_bit(20) | tap_bit(17);
            21: return tap_bit(21) | tap_bit(19);
            22: return tap_bit(22) | tap_bit(21);
            23: return tap_bit(23) | tap_bit(18);
            24: return tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
            25: return tap_bit(25) | tap_bit(22);
            26: return tap_bit(26) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
            27: return tap_bit(27) | tap_bit(5)  | tap_bit(2)  | tap_bit(1);
            28: return tap_bit(28) | tap_bit(25);
            29: return tap_bit(29) | tap_bit(27);
            30: return tap_bit(30) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
            31: return tap_bit(31) | tap_bit(28);
            32: return tap_bit(32) | tap_bit(22) | tap_bit(2)  | tap_bit(1);
            33: return tap_bit(33) | tap_bit(20);
            34: return tap_bit(34) | tap_bit(27) | tap_bit(2)  | tap_bit(1);
            35: return tap_bit(35) | tap_bit(33);
            36: return tap_bit(36) | tap_bit(25);
            37: return tap_bit(37) | tap_bit(5)  | tap_bit(4)  | tap_bit(3) | tap_bit(2) | tap_bit(1);
            38: return tap_bit(38) | tap_bit(6)  | tap_bit(5)  | tap_bit(1);
            39: return tap_bit(39) | tap_bit(35);
            40: return tap_bit(40) | tap_bit(38) | tap_bit(21) | tap_bit(19);
            41: return tap_bit(41) | tap_bit(38);
            42: return tap_bit(42) | tap_bit(41) | tap_bit(20) | tap_bit(19);
            43: return tap_bit(43) | tap_bit(42) | tap_bit(38) | tap_bit(37);
            44: return tap_bit(44) | tap_bit(43) | tap_bit(18) | tap_bit(17);
            45: return tap_bit(45) | tap_bit(44) | tap_bit(42) | tap_bit(41);
            46: return tap_bit(46) | tap_bit(45) | tap_bit(26) | tap_bit(25);
            47: return tap_bit(47) | tap_bit(42);
            48: return tap_bit(48) | tap_bit(47) | tap_bit(21) | tap_bit(20);
            49: return tap_bit(49) | tap_bit(40);
            50: return tap_bit(50) | tap_bit(49) | tap_bit(24) | tap_bit(23);
            51: return tap_bit(51) | tap_bit(50) | tap_bit(36) | tap_bit(35);
            52: return tap_bit(52) | tap_bit(49);
            53: return tap_bit(53) | tap_bit(52) | tap_bit(38) | tap_bit(37);
            54: return tap_bit(54) | tap_bit(53) | tap_bit(18) | tap_bit(17);
            55: return tap_bit(55) | tap_bit(31);
            56: return tap_bit(56) | tap_bit(55) | tap_bit(35) | tap_bit(34);
            57: return tap_bit(57) | tap_bit(50);
            58: return tap_bit(58) | tap_bit(39);
            59: return tap_bit(59) | tap_bit(58) | tap_bit(38) | tap_bit(37);
            60: return tap_bit(60) | tap_bit(59);
            61: return tap_bit(61) | tap_bit(60) | tap_bit(46) | tap_bit(45);
            62: return tap_bit(62) | tap_bit(61) | tap_bit(6)  | tap_bit(5);
            63: return tap_bit(63) | tap_bit(62);
            64: return tap_bit(64) | tap_bit(63) | tap_bit(61) | tap_bit(60);
            default: return 64'd0;
        endcase
    endfunction

endpackage

// File: rtl/antisat_pattern_lfsr.sv
// Right-shifting Galois LFSR that produces the per-key input pattern sequence.
module antisat_pattern_lfsr
    import antisat_sweep_pkg::*;
#(
    parameter int W = DEF_IN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] seed,
    output logic [W-1:0] value
);

    localparam logic [63:0]  TAPS_FULL = lfsr_taps(W);
    localparam logic [W-1:0] TAPS      = TAPS_FULL[W-1:0];

    logic [W-1:0] safe_seed;

    // An all-zero state would lock the LFSR up, so a zero seed is replaced by 1.
    assign safe_seed = (seed != '0) ? seed : W'(1);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            value <= safe_seed;
        end else if (step) begin
            value <= {1'b0, value[W-1:1]} ^ (value[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/antisat_key_sweeper.sv
// Brute-force key sweeper: applies each candidate key with a fixed pattern
// sequence to a locked netlist and reports the first key matching the oracle.
module antisat_key_sweeper
    import antisat_sweep_pkg::*;
#(
    parameter int              KEY_W     = DEF_KEY_W,
    parameter int              IN_W      = DEF_IN_W,
    parameter int              OUT_W     = DEF_OUT_W,
    parameter int              PAT_CNT   = 256,
    parameter logic [IN_W-1:0] LFSR_SEED = IN_W'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [KEY_W-1:0] start_key_i,
    output logic [KEY_W-1:0] key_o,
    output logic [IN_W-1:0]  pattern_o,
    input  logic [OUT_W-1:0] locked_out_i,
    input  logic [OUT_W-1:0] oracle_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             found_o,
    output logic [KEY_W-1:0] key_found_o,
    output logic [KEY_W:0]   keys_tested_o
);

    localparam int CNT_W = 17;

    sweep_state_t     state, state_next;
    logic [CNT_W-1:0] pat_cnt;
    logic [KEY_W-1:0] start_key_q;
    logic             pat_valid;
    logic [IN_W-1:0]  lfsr_value;
    logic             mismatch, last_pat, wrap;
    logic             lfsr_load, lfsr_step;

    assign mismatch = (locked_out_i != oracle_out_i);
    assign last_pat = (pat_cnt == CNT_W'(PAT_CNT - 1));
    assign wrap     = (key_o == (start_key_q - KEY_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = APPLY;
                    lfsr_load  = 1'b1;
                end
            end
            APPLY:    state_next = abort_i ? IDLE : CHECK;
            CHECK: begin
                if (abort_i)       state_next = IDLE;
                else if (mismatch) state_next = NEXT_KEY;
                else if (last_pat) state_next = DONE;
                else begin
                    state_next = APPLY;
                    lfsr_step  = 1'b1;
                end
            end
            NEXT_KEY: begin
                if (abort_i)   state_next = IDLE;
                else if (wrap) state_next = DONE;
                else begin
                    state_next = APPLY;
                    lfsr_load  = 1'b1;
                end
            end
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Result and key bookkeeping; abort only clears the result, key/pattern hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_o         <= '0;
            start_key_q   <= '0;
            pat_valid     <= 1'b0;
            pat_cnt       <= '0;
            keys_tested_o <= '0;
            found_o       <= 1'b0;
            key_found_o   <= '0;
        end else if (state == IDLE) begin
            if (start_i) begin
                key_o         <= start_key_i;
                start_key_q   <= start_key_i;
                pat_valid     <= 1'b1;
                pat_cnt       <= '0;
                keys_tested_o <= '0;
                found_o       <= 1'b0;
                key_found_o   <= '0;
            end
        end else if (abort_i) begin
            found_o     <= 1'b0;
            key_found_o <= '0;
        end else if (state == CHECK && !mismatch) begin
            if (last_pat) begin
                found_o       <= 1'b1;
                key_found_o   <= key_o;
                keys_tested_o <= keys_tested_o + (KEY_W+1)'(1);
            end else begin
                pat_cnt <= pat_cnt + CNT_W'(1);
            end
        end else if (state == NEXT_KEY) begin
            keys_tested_o <= keys_tested_o + (KEY_W+1)'(1);
            if (!wrap) begin
                key_o   <= key_o + KEY_W'(1);
                pat_cnt <= '0;
            end
        end
    end

    antisat_pattern_lfsr #(
        .W(IN_W)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .step (lfsr_step),
        .seed (LFSR_SEED),
        .value(lfsr_value)
    );

    // The LFSR resets to the seed, but pattern_o must read 0 until a sweep starts.
    assign pattern_o = pat_valid ? lfsr_value : '0;
    assign busy_o    = (state == APPLY) || (state == CHECK) || (state == NEXT_KEY);
    assign done_o    = (state == DONE);

endmodule

// File: tb/tb_antisat_key_sweeper.sv
// Directed bench for antisat_key_sweeper using a mock locked/oracle pair and a
// queue of expected sweep results.
module tb_antisat_key_sweeper;

    localparam int      KEY_W   = 8;
    localparam int      IN_W    = 36;
    localparam int      OUT_W   = 7;
    localparam int      PAT_CNT = 8;
    localparam logic [35:0] SEED     = 36'h1;
    localparam logic [35:0] TAP_MASK = 36'h801000000;
    localparam logic [7:0]  GOOD_KEY = 8'h5A;

    typedef struct {
        logic       found;
        logic [7:0] key_found;
        logic [8:0] keys_tested;
        logic [7:0] key_out;
        int         latency;
    } result_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic             abort_i;
    logic [KEY_W-1:0] start_key_i;
    logic [KEY_W-1:0] key_o;
    logic [IN_W-1:0]  pattern_o;
    logic [OUT_W-1:0] locked_out_i;
    logic [OUT_W-1:0] oracle_out_i;
    logic             busy_o;
    logic             done_o;
    logic             found_o;
    logic [KEY_W-1:0] key_found_o;
    logic [KEY_W:0]   keys_tested_o;

    logic        match_en;
    logic [35:0] seq [0:7];
    result_t     exp_q [$];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;

    antisat_key_sweeper #(
        .KEY_W(KEY_W), .IN_W(IN_W), .OUT_W(OUT_W), .PAT_CNT(PAT_CNT), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .start_key_i(start_key_i), .key_o(key_o), .pattern_o(pattern_o),
        .locked_out_i(locked_out_i), .oracle_out_i(oracle_out_i),
        .busy_o(busy_o), .done_o(done_o), .found_o(found_o),
        .key_found_o(key_found_o), .keys_tested_o(keys_tested_o)
    );

    always #5 clk = ~clk;

    // Mock circuits: the locked copy disagrees on the 4th pattern unless the key is right.
    always_comb begin
        oracle_out_i = pattern_o[6:0] ^ pattern_o[34:28];
        locked_out_i = oracle_out_i;
        if (!(match_en && key_o == GOOD_KEY) && pattern_o == seq[3])
            locked_out_i[0] = ~oracle_out_i[0];
    end

    function automatic logic [35:0] model_step(input logic [35:0] v);
        return {1'b0, v[35:1]} ^ (v[0] ? TAP_MASK : 36'h0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Pulses start (optionally with abort) and queues the result the sweep must produce.
    task automatic applyStimulus(input logic [7:0] k, input logic m_en, input logic with_abort);
        result_t r;
        int      off;
        match_en = m_en;
        if (m_en) begin
            off           = int'(8'(GOOD_KEY - k));
            r.found       = 1'b1;
            r.key_found   = GOOD_KEY;
            r.keys_tested = 9'(off + 1);
            r.key_out     = GOOD_KEY;
            r.latency     = 1 + off * 9 + 2 * PAT_CNT + 1;
        end else begin
            r.found       = 1'b0;
            r.key_found   = 8'h00;
            r.keys_tested = 9'd256;
            r.key_out     = 8'(k - 8'd1);
            r.latency     = 1 + 256 * 9 + 1;
        end
        exp_q.push_back(r);
        start_key_i = k;
        start_i     = 1'b1;
        abort_i     = with_abort;
        cyc         = 1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        result_t r;
        int      guard = 0;
        while (!done_o && guard < 5000) begin
            tick();
            guard++;
        end
        r = exp_q.pop_front();
        if (!done_o) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL %s_timeout: observed no done_o expected done_o", tag);
        end else begin
            checkOutput({tag, "_found"},   64'(found_o),       64'(r.found));
            checkOutput({tag, "_keyfound"}, 64'(key_found_o),  64'(r.key_found));
            checkOutput({tag, "_tested"},  64'(keys_tested_o), 64'(r.keys_tested));
            checkOutput({tag, "_key"},     64'(key_o),         64'(r.key_out));
            checkOutput({tag, "_latency"}, 64'(cyc),           64'(r.latency));
            checkOutput({tag, "_busy"},    64'(busy_o),        64'd0);
            tick();
            checkOutput({tag, "_done_pulse"}, 64'(done_o),  64'd0);
            checkOutput({tag, "_hold"},       64'(found_o), 64'(r.found));
        end
    endtask

    initial begin
        int done_seen;
        seq[0] = SEED;
        for (int i = 1; i < 8; i++) seq[i] = model_step(seq[i-1]);
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; start_key_i = '0; match_en = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checkOutput("rst_key",     64'(key_o),         64'd0);
        checkOutput("rst_pattern", 64'(pattern_o),     64'd0);
        checkOutput("rst_busy",    64'(busy_o),        64'd0);
        checkOutput("rst_done",    64'(done_o),        64'd0);
        checkOutput("rst_found",   64'(found_o),       64'd0);
        checkOutput("rst_keyfound",64'(key_found_o),   64'd0);
        checkOutput("rst_tested",  64'(keys_tested_o), 64'd0);

        $display("[TB] sweep from 00 to matching key 5A");
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("a_busy_up",  64'(busy_o),    64'd1);
        checkOutput("a_pattern0", 64'(pattern_o), 64'(seq[0]));
        checkOutput("a_key0",     64'(key_o),     64'h00);
        tick(); tick();
        checkOutput("a_pattern1", 64'(pattern_o), 64'(seq[1]));
        waitDone("a");

        $display("[TB] start while busy is ignored");
        applyStimulus(8'h50, 1'b1, 1'b0);
        repeat (4) tick();
        start_key_i = 8'h00;
        start_i     = 1'b1;
        tick();
        start_i = 1'b0;
        waitDone("busy_start");

        $display("[TB] abort mid-sweep");
        applyStimulus(8'h00, 1'b1, 1'b0);
        void'(exp_q.pop_back());
        while (cyc < 11) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        checkOutput("abort_busy",     64'(busy_o),      64'd0);
        checkOutput("abort_found",    64'(found_o),     64'd0);
        checkOutput("abort_keyfound", 64'(key_found_o), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_o) done_seen++;
        end
        checkOutput("abort_no_done", 64'(done_seen), 64'd0);

        $display("[TB] start with abort in IDLE");
        applyStimulus(8'h58, 1'b1, 1'b1);
        checkOutput("startabort_busy", 64'(busy_o), 64'd1);
        waitDone("startabort");

        $display("[TB] no matching key, full wrap from F0");
        applyStimulus(8'hF0, 1'b0, 1'b0);
        waitDone("nomatch");

        $display("[TB] reset during CHECK");
        applyStimulus(8'h00, 1'b1, 1'b0);
        void'(exp_q.pop_back());
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_key",     64'(key_o),         64'd0);
        checkOutput("midrst_busy",    64'(busy_o),        64'd0);
        checkOutput("midrst_tested",  64'(keys_tested_o), 64'd0);
        checkOutput("midrst_pattern", 64'(pattern_o),     64'd0);
        repeat (3) tick();
        checkOutput("midrst_pattern_hold", 64'(pattern_o), 64'd0);
        checkOutput("midrst_done",         64'(done_o),    64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
